// File: rtl/dmem_responder.sv
// Byte-addressed, big-endian data memory with a fixed-latency request/response handshake.
// Optional macro DMEM_RESPONDER_ALIGN_CHECK_EN rejects misaligned half-word/word accesses.
module dmem_responder #(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:31] addr,
  input  logic        write_enable,
  input  logic        mem_byte,
  input  logic        mem_half_word,
  input  logic        sign_extend,
  input  logic [0:31] data_in,
  output logic        resp_valid,
  output logic [0:31] data_out,
  output logic        misalign_err
);

  localparam int AW = $clog2(SIZE);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [7:0] mem [0:SIZE-1];

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d, byte_q, byte_d, half_q, half_d, sx_q, sx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     addr_v, din_v;
  logic            unused_addr_bits;
  logic            in_idle, enter_resp, mis, do_write;
  logic [AW-1:0]   s_addr, a0, a1, a2, a3;
  logic            s_we, s_byte, s_half, s_sx;
  logic [31:0]     s_wdata, rd;

  assign addr_v           = addr;
  assign din_v            = data_in;
  assign unused_addr_bits = ^addr_v[31:AW];

  always_comb begin
    in_idle = (state_q == IDLE);
    // With LATENCY=0 the access happens on the accepting edge, so the live inputs are the source.
    s_addr  = in_idle ? addr_v[AW-1:0] : addr_q;
    s_we    = in_idle ? write_enable   : we_q;
    s_byte  = in_idle ? mem_byte       : byte_q;
    s_half  = in_idle ? mem_half_word  : half_q;
    s_sx    = in_idle ? sign_extend    : sx_q;
    s_wdata = in_idle ? din_v          : wdata_q;

    enter_resp = reset_n && ((in_idle && req_valid && (LATENCY == 0)) ||
                             ((state_q == WAIT) && (cnt_q == 4'd0)));

    a0  = s_addr;
    mis = 1'b0;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    mis = !s_byte && ((s_half && s_addr[0]) || (!s_half && (s_addr[1:0] != 2'b00)));
`else
    if (!s_byte && s_half)  a0[0]   = 1'b0;
    if (!s_byte && !s_half) a0[1:0] = 2'b00;
`endif
    a1 = a0 + AW'(1);
    a2 = a0 + AW'(2);
    a3 = a0 + AW'(3);

    if (s_byte)      rd = {{24{s_sx & mem[a0][7]}}, mem[a0]};
    else if (s_half) rd = {{16{s_sx & mem[a0][7]}}, mem[a0], mem[a1]};
    else             rd = {mem[a0], mem[a1], mem[a2], mem[a3]};

    do_write = enter_resp && s_we && !mis;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    byte_d  = byte_q;
    half_d  = half_q;
    sx_d    = sx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = addr_v[AW-1:0];
          we_d    = write_enable;
          byte_d  = mem_byte;
          half_d  = mem_half_word;
          sx_d    = sign_extend;
          wdata_d = din_v;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      err_d   = mis;
      rdata_d = (s_we || mis) ? 32'd0 : rd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      sx_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      half_q  <= half_d;
      sx_q    <= sx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset so contents survive reset_n.
  always_ff @(posedge clock) begin
    if (do_write) begin
      if (s_byte) begin
        mem[a0] <= s_wdata[7:0];
      end else if (s_half) begin
        mem[a0] <= s_wdata[15:8];
        mem[a1] <= s_wdata[7:0];
      end else begin
        mem[a0] <= s_wdata[31:24];
        mem[a1] <= s_wdata[23:16];
        mem[a2] <= s_wdata[15:8];
        mem[a3] <= s_wdata[7:0];
      end
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign data_out     = resp_valid ? rdata_q : 32'd0;
  assign misalign_err = resp_valid & err_q;

endmodule
